// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the packet framer and deframer around the dual-clock FIFO:
// FSM states, trailer magic byte, trailer field layout and a trailer builder.
package fifo_pkt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TRAIL = 2'd2
  } pkt_state_e;

  localparam logic [7:0] TRAILER_MAGIC = 8'hA5;

  localparam int MAGIC_MSB = 31;
  localparam int MAGIC_LSB = 24;
  localparam int LEN_MSB   = 23;
  localparam int LEN_LSB   = 8;
  localparam int CSUM_MSB  = 7;
  localparam int CSUM_LSB  = 0;

  function automatic logic [31:0] build_trailer(input logic [15:0] len, input logic [7:0] csum);
    logic [31:0] t;
    t = 32'h0000_0000;
    t[MAGIC_MSB:MAGIC_LSB] = TRAILER_MAGIC;
    t[LEN_MSB:LEN_LSB]     = len;
    t[CSUM_MSB:CSUM_LSB]   = csum;
    return t;
  endfunction

endpackage

// File: rtl/fifo_pkt_trailer_acc.sv
// Per-packet length and byte-XOR checksum accumulator. Length saturates at all-ones;
// a word arriving at saturation sets a sticky overflow flag that only reset clears.
module fifo_pkt_trailer_acc
  import fifo_pkt_pkg::*;
#(
  parameter int LW = 16
) (
  input  logic          wr_clk,
  input  logic          wr_reset_n,
  input  logic          i_load,
  input  logic          i_accum,
  input  logic          i_clear,
  input  logic [7:0]    i_byte,
  output logic [LW-1:0] o_len,
  output logic [7:0]    o_csum,
  output logic          o_ovf
);

  logic [LW-1:0] r_len;
  logic [7:0]    r_csum;
  logic          r_ovf;

  // Length, checksum and overflow flag update
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_len  <= '0;
      r_csum <= 8'h00;
      r_ovf  <= 1'b0;
    end else if (i_clear) begin
      r_len  <= '0;
      r_csum <= 8'h00;
    end else if (i_load) begin
      r_len  <= LW'(1);
      r_csum <= i_byte;
    end else if (i_accum) begin
      r_csum <= r_csum ^ i_byte;
      if (r_len == {LW{1'b1}}) begin
        r_ovf <= 1'b1;
      end else begin
        r_len <= r_len + LW'(1);
      end
    end
  end

  assign o_len  = r_len;
  assign o_csum = r_csum;
  assign o_ovf  = r_ovf;

endmodule

// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer: passes payload straight into the FIFO write port and
// appends a magic/length/checksum trailer word after each packet.
module fifo_pkt_writer
  import fifo_pkt_pkg::*;
#(
  parameter int DW = 32,
  parameter int LW = 16
) (
  input  logic          wr_clk,
  input  logic          wr_reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_wr_data,
  input  logic          fifo_full,
  input  logic          fifo_afull,
  output logic [15:0]   pkt_cnt,
  output logic          len_ovf
);

  pkt_state_e    r_state;
  pkt_state_e    w_state_next;
  logic          w_ready;
  logic          w_wr_en;
  logic [DW-1:0] w_wr_data;
  logic          w_load;
  logic          w_accum;
  logic          w_clear;
  logic [LW-1:0] w_len;
  logic [7:0]    w_csum;
  logic          w_ovf;
  logic [15:0]   r_pkt_cnt;

  fifo_pkt_trailer_acc #(.LW(LW)) u_acc (
    .wr_clk     (wr_clk),
    .wr_reset_n (wr_reset_n),
    .i_load     (w_load),
    .i_accum    (w_accum),
    .i_clear    (w_clear),
    .i_byte     (s_data[7:0]),
    .o_len      (w_len),
    .o_csum     (w_csum),
    .o_ovf      (w_ovf)
  );

  // FSM state register
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, handshake and FIFO write muxing
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_data    = '0;
    w_load       = 1'b0;
    w_accum      = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        // afull only gates the start of a packet
        w_ready = !fifo_afull && !fifo_full;
        if (s_valid && w_ready) begin
          w_wr_en   = 1'b1;
          w_wr_data = s_data;
          w_load    = 1'b1;
          if (s_last) begin
            w_state_next = TRAIL;
          end else begin
            w_state_next = DATA;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      DATA: begin
        w_ready = !fifo_full;
        if (s_valid && w_ready) begin
          w_wr_en   = 1'b1;
          w_wr_data = s_data;
          w_accum   = 1'b1;
          if (s_last) begin
            w_state_next = TRAIL;
          end else begin
            w_state_next = DATA;
          end
        end else begin
          w_state_next = DATA;
        end
      end
      TRAIL: begin
        if (!fifo_full) begin
          w_wr_en         = 1'b1;
          w_wr_data[31:0] = build_trailer(w_len, w_csum);
          w_clear         = 1'b1;
          w_state_next    = IDLE;
        end else begin
          w_state_next = TRAIL;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Completed-packet counter, advances as each trailer is written
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      r_pkt_cnt <= 16'h0000;
    end else if (w_clear) begin
      r_pkt_cnt <= r_pkt_cnt + 16'h0001;
    end
  end

  assign s_ready      = wr_reset_n ? w_ready   : 1'b0;
  assign fifo_wr_en   = wr_reset_n ? w_wr_en   : 1'b0;
  assign fifo_wr_data = wr_reset_n ? w_wr_data : '0;
  assign pkt_cnt      = r_pkt_cnt;
  assign len_ovf      = w_ovf;

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Self-checking bench for fifo_pkt_writer: directed steps plus randomized packets
// scored against an expected-write queue built from packet contents.
module tb_fifo_pkt_writer;

  logic        wr_clk;
  logic        wr_reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_full;
  logic        fifo_afull;
  logic [15:0] pkt_cnt;
  logic        len_ovf;

  typedef struct {
    logic [31:0] data;
    bit          trl;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pw[$];
  int          checks;
  int          failures;
  int          cyc;
  int          acc_cyc;
  int          trl_cyc;
  bit          acc;
  logic [31:0] last_trl;
  logic [15:0] exp_pkt;
  logic        exp_ovf;

  fifo_pkt_writer #(.DW(32), .LW(16)) dut (
    .wr_clk       (wr_clk),
    .wr_reset_n   (wr_reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .pkt_cnt      (pkt_cnt),
    .len_ovf      (len_ovf)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle sample: scoreboard every FIFO write and the full-related rules
  task automatic sample();
    exp_t e;
    @(negedge wr_clk);
    cyc++;
    acc = s_valid && s_ready;
    if (acc) acc_cyc = cyc;
    if (fifo_full) chk("ready_while_full", s_ready, 1'b0);
    if (fifo_wr_en) begin
      chk("wr_while_full", fifo_full, 1'b0);
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", fifo_wr_en, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk(e.trl ? "trailer_data" : "payload_data", fifo_wr_data, e.data);
        if (e.trl) begin
          last_trl = fifo_wr_data;
          trl_cyc  = cyc;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge wr_clk);
    #1;
  endtask

  // Reference framing: payload words in order, then magic/len/xor trailer
  task automatic push_exp();
    logic [7:0]  cs;
    logic [15:0] ln;
    int          n;
    cs = 8'h00;
    n  = pw.size();
    foreach (pw[i]) begin
      exp_q.push_back('{pw[i], 1'b0});
      cs = cs ^ pw[i][7:0];
    end
    ln = (n > 65535) ? 16'hFFFF : n[15:0];
    exp_q.push_back('{{8'hA5, ln, cs}, 1'b1});
    if (n > 65535) exp_ovf = 1'b1;
  endtask

  task automatic finish_pkt(input bit chk_lat);
    int budget;
    s_valid = 1'b0;
    s_last  = 1'b0;
    budget  = 0;
    while (exp_q.size() > 0 && budget < 100) begin
      sample();
      advance();
      budget++;
    end
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    if (chk_lat) chk("trl_latency", trl_cyc - acc_cyc, 1);
    exp_pkt = exp_pkt + 16'd1;
    chk("pkt_cnt", pkt_cnt, exp_pkt);
    chk("len_ovf", len_ovf, exp_ovf);
  endtask

  task automatic send_pkt(input int full_pct, input int gap_pct, input int afull_pct);
    int budget;
    push_exp();
    for (int i = 0; i < pw.size(); i++) begin
      s_data = pw[i];
      s_last = (i == pw.size() - 1);
      budget = 0;
      acc    = 1'b0;
      while (!acc && budget < 200) begin
        s_valid    = ($urandom_range(99) >= gap_pct);
        fifo_full  = ($urandom_range(99) < full_pct);
        fifo_afull = ($urandom_range(99) < afull_pct);
        sample();
        advance();
        budget++;
      end
      if (!acc) begin
        chk("accept_timeout", acc, 1'b1);
        break;
      end
    end
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    finish_pkt(full_pct == 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    acc_cyc  = 0;
    trl_cyc  = 0;
    acc      = 1'b0;
    last_trl = 32'h0;
    exp_pkt  = 16'h0;
    exp_ovf  = 1'b0;

    // Reset: outputs forced low even with upstream valid
    wr_reset_n = 1'b0;
    s_valid    = 1'b1;
    s_data     = 32'hDEAD_BEEF;
    s_last     = 1'b1;
    fifo_full  = 1'b0;
    fifo_afull = 1'b0;
    sample();
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_wr_data", fifo_wr_data, 32'h0);
    chk("rst_pkt_cnt", pkt_cnt, 16'h0);
    chk("rst_len_ovf", len_ovf, 1'b0);
    advance();
    wr_reset_n = 1'b1;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    advance();

    // 3-word packet
    pw = {32'h11, 32'h22, 32'h33};
    send_pkt(0, 0, 0);
    chk("t3_trailer", last_trl, 32'hA500_0300);

    // Single-word packet, then back in IDLE
    pw = {32'h0000_00FF};
    send_pkt(0, 0, 0);
    chk("t1_trailer", last_trl, 32'hA500_01FF);
    sample();
    chk("t1_idle_ready", s_ready, 1'b1);
    advance();

    // fifo_full stall mid-packet and on the trailer
    pw = {32'hA1, 32'hB2, 32'hC3, 32'hD4};
    push_exp();
    s_valid = 1'b1; s_data = 32'hA1; s_last = 1'b0;
    sample(); chk("st_w0", acc, 1'b1); advance();
    s_data = 32'hB2;
    sample(); chk("st_w1", acc, 1'b1); advance();
    s_data = 32'hC3; fifo_full = 1'b1;
    repeat (4) begin
      sample();
      chk("st_ready_low", s_ready, 1'b0);
      chk("st_no_wr", fifo_wr_en, 1'b0);
      advance();
    end
    fifo_full = 1'b0;
    sample(); chk("st_w2", acc, 1'b1); advance();
    s_data = 32'hD4; s_last = 1'b1;
    sample(); chk("st_w3", acc, 1'b1); advance();
    s_valid = 1'b0; s_last = 1'b0; fifo_full = 1'b1;
    repeat (4) begin
      sample();
      chk("st_trl_held", fifo_wr_en, 1'b0);
      advance();
    end
    fifo_full = 1'b0;
    sample(); chk("st_trl_wr", fifo_wr_en, 1'b1); advance();
    finish_pkt(1'b0);
    chk("st_trailer", last_trl, 32'hA500_0400 | 32'(8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4));

    // afull blocks a packet start but not a packet in flight
    pw = {32'hE1, 32'hE2, 32'hE3};
    push_exp();
    fifo_afull = 1'b1; s_valid = 1'b1; s_data = 32'hE1; s_last = 1'b0;
    repeat (3) begin
      sample();
      chk("af_idle_ready", s_ready, 1'b0);
      chk("af_idle_no_wr", fifo_wr_en, 1'b0);
      advance();
    end
    fifo_afull = 1'b0;
    sample(); chk("af_w0", acc, 1'b1); advance();
    fifo_afull = 1'b1; s_data = 32'hE2;
    sample(); chk("af_mid_ready", s_ready, 1'b1); advance();
    s_data = 32'hE3; s_last = 1'b1;
    sample(); chk("af_w2", acc, 1'b1); advance();
    s_valid = 1'b0; s_last = 1'b0;
    sample(); chk("af_trl_wr", fifo_wr_en, 1'b1); advance();
    finish_pkt(1'b0);

    // Randomized packets with gaps, full and afull
    for (int p = 0; p < 20; p++) begin
      pw.delete();
      for (int w = 0; w < int'($urandom_range(6, 1)); w++) pw.push_back($urandom);
      send_pkt(25, 25, 20);
    end

    // Length saturation and sticky overflow
    pw.delete();
    for (int i = 0; i < 65537; i++) pw.push_back(32'(i) ^ 32'h5A5A_0000);
    send_pkt(0, 0, 0);
    chk("big_len_field", last_trl[23:8], 16'hFFFF);
    chk("big_len_ovf", len_ovf, 1'b1);
    for (int p = 0; p < 2; p++) begin
      pw.delete();
      for (int w = 0; w < int'($urandom_range(5, 1)); w++) pw.push_back($urandom);
      send_pkt(20, 20, 0);
    end
    chk("ovf_sticky", len_ovf, 1'b1);

    // Reset after 2 words of a 5-word packet
    pw = {32'hC0DE_0001, 32'hC0DE_0002};
    foreach (pw[i]) exp_q.push_back('{pw[i], 1'b0});
    s_valid = 1'b1; s_last = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_data = pw[i];
      sample(); chk("rm_accept", acc, 1'b1); advance();
    end
    chk("rm_pre_writes", exp_q.size(), 0);
    exp_q.delete();
    wr_reset_n = 1'b0;
    s_data = 32'hC0DE_0003;
    sample();
    chk("rm_s_ready", s_ready, 1'b0);
    chk("rm_wr_en", fifo_wr_en, 1'b0);
    chk("rm_wr_data", fifo_wr_data, 32'h0);
    chk("rm_pkt_cnt", pkt_cnt, 16'h0);
    chk("rm_len_ovf", len_ovf, 1'b0);
    advance();
    wr_reset_n = 1'b1;
    s_valid = 1'b0;
    exp_pkt = 16'h0;
    exp_ovf = 1'b0;
    advance();
    pw = {32'h0000_0010, 32'h0000_0020, 32'h0000_0041};
    send_pkt(0, 0, 0);
    chk("rm_next_trailer", last_trl, 32'hA500_0371);
    chk("rm_next_pkt_cnt", pkt_cnt, 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
